// File: rtl/hwpe_stream_tcdm_linear_reader.sv
// TCDM linear reader: issues single-word reads along base + k*stride and
// presents the responses as a 32-bit stream through a credit-controlled buffer.
module hwpe_stream_tcdm_linear_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_WIDTH-1:0] word_count_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic                 tcdm_gnt_i,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic                 stream_valid_o,
  output logic [31:0]          stream_data_o,
  output logic [3:0]           stream_strb_o,
  input  logic                 stream_ready_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W:0]   OCC_FULL = (OCC_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          stride_q, stride_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] accepted_q, accepted_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic                 done_zero_q, done_zero_d;

  logic [31:0]          mem_q [FIFO_DEPTH];

  logic                 push, pop, grant, stream_valid;
  logic                 has_credit, last_issue, last_accept;
  logic [OCC_W:0]       used;

  // A response is only accepted when its grant was issued outside a clear cycle.
  assign push         = tcdm_r_valid_i & inflight_q;
  assign stream_valid = (occ_q != '0);
  assign pop          = stream_valid & stream_ready_i;
  assign used         = {1'b0, occ_q} + (OCC_W + 1)'(inflight_q);
  assign has_credit   = (used < OCC_FULL);
  assign last_issue   = ((issued_q + CNT_WIDTH'(1)) == count_q);
  assign last_accept  = ((accepted_q + CNT_WIDTH'(1)) == count_q);

  assign tcdm_req_o   = (state_q == RUN) && has_credit && (issued_q < count_q);
  assign tcdm_add_o   = addr_q;
  assign tcdm_wen_o   = 1'b1;
  assign tcdm_be_o    = 4'hF;
  assign tcdm_data_o  = '0;
  assign grant        = tcdm_req_o & tcdm_gnt_i;

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_zero_q | ((state_q == DRAIN) & pop & last_accept);
  assign stream_valid_o = stream_valid;
  assign stream_data_o  = stream_valid ? mem_q[rptr_q] : '0;
  assign stream_strb_o  = stream_valid ? 4'hF : 4'h0;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    count_d     = count_q;
    issued_d    = issued_q;
    accepted_d  = accepted_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    occ_d       = occ_q;
    inflight_d  = grant;
    done_zero_d = 1'b0;

    if (clear_i) begin
      state_d    = IDLE;
      issued_d   = '0;
      accepted_d = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      occ_d      = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
      if (pop)  rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_d     = base_addr_i;
            stride_d   = stride_i;
            count_d    = word_count_i;
            issued_d   = '0;
            accepted_d = '0;
            if (word_count_i == '0) done_zero_d = 1'b1;
            else                    state_d     = RUN;
          end
        end
        RUN: begin
          if (grant) begin
            addr_d   = addr_q + stride_q;
            issued_d = issued_q + CNT_WIDTH'(1);
            if (last_issue) state_d = DRAIN;
          end
          if (pop) accepted_d = accepted_q + CNT_WIDTH'(1);
        end
        DRAIN: begin
          if (pop) begin
            accepted_d = accepted_q + CNT_WIDTH'(1);
            if (last_accept) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      done_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      accepted_q  <= accepted_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      done_zero_q <= done_zero_d;
    end
  end

  // Buffer storage carries data only; validity lives in occ_q.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem_q[wptr_q] <= tcdm_r_data_i;
  end

endmodule

// File: doc/hwpe_stream_tcdm_linear_reader.md
Name: hwpe_stream_tcdm_linear_reader

Overview:
- Source stage that produces an `hwpe_stream_intf_stream` (DATA_WIDTH=32) from the TCDM.
- Acts as a TCDM master: issues single-word reads along a linear address pattern (base, stride, count).
- A small credit-controlled buffer decouples TCDM grant/response timing from stream backpressure.
- Sits directly upstream of stream consumers (FIFOs, serializers, engine datapaths) inside an HWPE streamer.

Parameters:
- FIFO_DEPTH, 4, response buffer entries and maximum outstanding reads; must be ≥2.
- CNT_WIDTH, 16, width of the word-count input and internal counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- start_i  in  1  latch config and start a transfer (IDLE only)
- base_addr_i  in  32  byte address of first word
- stride_i  in  32  byte increment between words
- word_count_i  in  CNT_WIDTH  number of words to read
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse when the last word is accepted on the stream
- tcdm_req_o, tcdm_add_o[31:0], tcdm_wen_o, tcdm_be_o[3:0], tcdm_data_o[31:0]  out  TCDM master request side
- tcdm_gnt_i, tcdm_r_data_i[31:0], tcdm_r_valid_i  in  TCDM master response side
- stream_valid_o, stream_data_o[31:0], stream_strb_o[3:0]  out  stream source
- stream_ready_i  in  1  stream sink ready

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; all counters 0.
- Constant outputs: tcdm_wen_o=1 (read), tcdm_be_o=4'hF, tcdm_data_o=0.
- stream_strb_o=4'hF whenever stream_valid_o=1, otherwise 0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start_i=1 latches base/stride/count.
  - count≠0 → RUN next cycle.
  - count=0 → done_o pulses next cycle, no TCDM activity, stays IDLE.
  - start_i ignored in RUN/DRAIN.
- busy_o=1 in RUN and DRAIN.
- RUN, request side:
  - Request k (0-based) uses address base + k*stride, modulo 2^32 (wrap, no error).
  - credits = FIFO_DEPTH − (FIFO occupancy + in-flight grants).
  - tcdm_req_o rises only when credits>0 and issued<count.
  - Once raised, req and add are held stable until tcdm_gnt_i=1 (credits cannot shrink meanwhile).
  - Back-to-back requests are allowed: next request may be presented the cycle after a grant.
- Response path:
  - TCDM returns tcdm_r_valid_i exactly one cycle after gnt.
  - Response data is pushed into the FIFO; the FIFO never overflows by construction.
  - Data returns in request order.
- RUN→DRAIN when the last request is granted.
- DRAIN→IDLE when the last word is accepted (stream_valid_o & stream_ready_i). done_o pulses in that same handshake cycle and busy_o drops the next cycle.
- Stream rules:
  - stream_valid_o = FIFO non-empty; stream_data_o = FIFO head.
  - While valid=1 and ready=0, data and strb must not change and valid must not deassert.
- FIFO simultaneous push and pop: occupancy unchanged and ordering preserved. When empty, a push is visible on the stream the cycle after r_valid (latency gnt→stream valid = 2 cycles).
- clear_i (any state):
  - Next cycle: IDLE, FIFO empty, counters 0, req deasserted; no done_o.
  - A tcdm_r_valid_i arriving the cycle after clear_i, from a grant in the clear_i cycle, is discarded.
  - clear_i has priority over start_i.
- Async reset mid-transfer: immediate return to reset values.

Test Plan:
- Zero-wait throughput: base=0x1000, stride=4, count=8, gnt always 1, ready always 1.
  - Addresses 0x1000..0x101C on 8 consecutive cycles.
  - Stream beats equal memory contents in order.
  - done_o pulses once on the 8th handshake.
- Backpressure: count=10, ready=0 for the first 20 cycles.
  - Exactly FIFO_DEPTH=4 requests granted, then req stays 0.
  - stream_data_o stays stable.
  - After ready=1, all 10 words are delivered in order.
- Grant stalls: gnt randomly low (≈50%).
  - req/add held stable each cycle until gnt.
  - No duplicated or skipped addresses.
- Wrap and stride: base=0xFFFFFFF8, stride=4, count=4 → addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Count zero, and start while busy:
  - count=0 → done_o on the next cycle, tcdm_req_o never asserted.
  - start_i pulsed during RUN → ignored, original transfer completes unchanged.
- Clear mid-transfer: assert clear_i in the same cycle as a grant.
  - The following r_valid is dropped.
  - Next cycle: stream_valid_o=0 and busy_o=0, no done_o.
  - A new transfer started afterwards produces correct data.
